// File: rtl/unsigned_divider.sv
// Sequential restoring divider for normalized mantissas: one quotient bit per
// clock, normalized fraction plus guard/sticky/norm_shift for the rounder.
module unsigned_divider #(
  parameter int BIT_WIDTH = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] in0,
  input  logic [BIT_WIDTH-1:0] in1,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 guard,
  output logic                 sticky,
  output logic                 norm_shift
);

  localparam int N  = BIT_WIDTH + 3;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t               state;
  logic [BIT_WIDTH+1:0] rem;
  logic [BIT_WIDTH+1:0] rem_diff;
  logic [BIT_WIDTH:0]   div;
  logic [N-1:0]         quo;
  logic [N-1:0]         quo_next;
  logic [CW-1:0]        cnt;
  logic                 qbit;

  // One restoring step; rem_diff < div, so the left shift never drops a set bit.
  always_comb begin
    qbit     = (rem >= {1'b0, div});
    rem_diff = qbit ? (rem - {1'b0, div}) : rem;
    quo_next = {quo[N-2:0], qbit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      div        <= '0;
      quo        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out        <= '0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
      norm_shift <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div   <= {1'b1, in1};
            rem   <= {2'b01, in0};
            quo   <= '0;
            cnt   <= CW'(N);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          rem <= rem_diff << 1;
          quo <= quo_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // Quotient lies in (0.5, 2): top bit set means no normalization shift.
            if (quo_next[N-1]) begin
              out        <= quo_next[N-2:2];
              guard      <= quo_next[1];
              sticky     <= quo_next[0] | (rem_diff != '0);
              norm_shift <= 1'b0;
            end else begin
              out        <= quo_next[N-3:1];
              guard      <= quo_next[0];
              sticky     <= (rem_diff != '0);
              norm_shift <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
